// File: rtl/mmx_scoreboard.sv
// mmx_scoreboard: per-register pending-write scoreboard for the eight MMX registers
module mmx_scoreboard #(
    parameter int CNT_W       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dec_valid,
    input  logic                   mm1_needed,
    input  logic                   mm2_needed,
    input  logic [2:0]             mm1,
    input  logic [2:0]             mm2,
    input  logic                   ld_mm,
    input  logic [2:0]             dmm,
    input  logic                   ds_stall,
    input  logic                   wb_ld_mm,
    input  logic [2:0]             wb_dmm,
    input  logic                   flush,
    output logic                   mm_stall,
    output logic                   mm_issue,
    output logic [7:0]             pend_mask,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   sb_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]       cnt_q [8];
    logic [CNT_W-1:0]       cnt_d [8];
    logic [CNT_W-1:0]       eff [8];
    logic [7:0]             wb_hit;
    logic [7:0]             inc;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   sb_err_q, sb_err_d;
    logic                   raw_hz, full_hz, wb_spur;

    // Effective counts: a writeback this cycle already frees its register for hazard checks
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            wb_hit[i]    = wb_ld_mm && (wb_dmm == 3'(i)) && (cnt_q[i] != '0);
            eff[i]       = wb_hit[i] ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
            pend_mask[i] = |cnt_q[i];
        end
    end

    assign raw_hz   = (mm1_needed && (eff[mm1] != '0)) || (mm2_needed && (eff[mm2] != '0));
    assign full_hz  = ld_mm && (eff[dmm] == CNT_MAX);
    assign mm_stall = dec_valid && !flush && (raw_hz || full_hz);
    assign mm_issue = dec_valid && !flush && !mm_stall && !ds_stall;

    // Next state: flush wipes counters and discards a same-cycle writeback
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            inc[i]   = mm_issue && ld_mm && (dmm == 3'(i));
            cnt_d[i] = flush                    ? '0 :
                       (inc[i] && !wb_hit[i])   ? cnt_q[i] + CNT_W'(1) :
                       (!inc[i] && wb_hit[i])   ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
        end
        wb_spur     = wb_ld_mm && (cnt_q[wb_dmm] == '0);
        sb_err_d    = sb_err_q || (!flush && wb_spur);
        stall_cnt_d = (dec_valid && mm_stall && (stall_cnt_q != '1)) ? stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;
    end

    // State registers, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
            stall_cnt_q <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
            stall_cnt_q <= stall_cnt_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign sb_err    = sb_err_q;
endmodule

// File: tb/tb_mmx_scoreboard.sv
// tb_mmx_scoreboard: directed scenarios for the MMX pending-write scoreboard
module tb_mmx_scoreboard;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dec_valid, mm1_needed, mm2_needed, ld_mm, ds_stall, wb_ld_mm, flush;
    logic [2:0]  mm1, mm2, dmm, wb_dmm;
    logic        mm_stall, mm_issue, sb_err;
    logic [7:0]  pend_mask;
    logic [15:0] stall_cnt;
    int          n_cmp = 0;
    int          n_err = 0;

    mmx_scoreboard #(.CNT_W(2), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .mm1_needed(mm1_needed),
        .mm2_needed(mm2_needed), .mm1(mm1), .mm2(mm2), .ld_mm(ld_mm), .dmm(dmm),
        .ds_stall(ds_stall), .wb_ld_mm(wb_ld_mm), .wb_dmm(wb_dmm), .flush(flush),
        .mm_stall(mm_stall), .mm_issue(mm_issue), .pend_mask(pend_mask),
        .stall_cnt(stall_cnt), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        dec_valid = 0; mm1_needed = 0; mm2_needed = 0; ld_mm = 0; ds_stall = 0;
        wb_ld_mm = 0; flush = 0; mm1 = 0; mm2 = 0; dmm = 0; wb_dmm = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_write(input logic [2:0] r);
        idle(); dec_valid = 1; ld_mm = 1; dmm = r;
        step();
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        step();
        n_cmp++; if (pend_mask !== 8'h00) begin n_err++; $display("FAIL reset_pend: got %h want 00", pend_mask); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        n_cmp++; if (sb_err !== 1'b0) begin n_err++; $display("FAIL reset_sb_err: got %b want 0", sb_err); end
        n_cmp++; if ({mm_stall, mm_issue} !== 2'b00) begin n_err++; $display("FAIL reset_stall_issue: got %b want 00", {mm_stall, mm_issue}); end
        rst = 0;
        step();
    endtask

    task automatic test_basic_raw();
        idle(); dec_valid = 1; ld_mm = 1; dmm = 3; mm1_needed = 1; mm1 = 3;
        #1;
        n_cmp++; if ({mm_stall, mm_issue} !== 2'b01) begin n_err++; $display("FAIL raw_self_write: got %b want 01", {mm_stall, mm_issue}); end
        step();
        idle(); dec_valid = 1; mm1_needed = 1; mm1 = 3;
        #1;
        n_cmp++; if (pend_mask !== 8'h08) begin n_err++; $display("FAIL raw_pend: got %h want 08", pend_mask); end
        n_cmp++; if ({mm_stall, mm_issue} !== 2'b10) begin n_err++; $display("FAIL raw_stall: got %b want 10", {mm_stall, mm_issue}); end
        step();
        wb_ld_mm = 1; wb_dmm = 3;
        #1;
        n_cmp++; if ({mm_stall, mm_issue} !== 2'b01) begin n_err++; $display("FAIL raw_bypass: got %b want 01", {mm_stall, mm_issue}); end
        step();
        idle();
        #1;
        n_cmp++; if (pend_mask !== 8'h00) begin n_err++; $display("FAIL raw_drained: got %h want 00", pend_mask); end
        n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL raw_stall_cnt: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_counter_full();
        for (int k = 0; k < 3; k++) begin
            idle(); dec_valid = 1; ld_mm = 1; dmm = 5;
            #1;
            n_cmp++; if (mm_issue !== 1'b1) begin n_err++; $display("FAIL full_issue%0d: got %b want 1", k, mm_issue); end
            step();
        end
        idle(); dec_valid = 1; ld_mm = 1; dmm = 5;
        #1;
        n_cmp++; if (pend_mask !== 8'h20) begin n_err++; $display("FAIL full_pend: got %h want 20", pend_mask); end
        n_cmp++; if ({mm_stall, mm_issue} !== 2'b10) begin n_err++; $display("FAIL full_stall: got %b want 10", {mm_stall, mm_issue}); end
        step();
        wb_ld_mm = 1; wb_dmm = 5;
        #1;
        n_cmp++; if ({mm_stall, mm_issue} !== 2'b01) begin n_err++; $display("FAIL full_release: got %b want 01", {mm_stall, mm_issue}); end
        step();
        idle(); wb_ld_mm = 1; wb_dmm = 5;
        step();
        step();
        n_cmp++; if (pend_mask !== 8'h20) begin n_err++; $display("FAIL full_cnt_kept: got %h want 20", pend_mask); end
        step();
        idle();
        #1;
        n_cmp++; if ({pend_mask, sb_err} !== 9'h000) begin n_err++; $display("FAIL full_drain: got %h want 000", {pend_mask, sb_err}); end
        n_cmp++; if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL full_stall_cnt: got %0d want 2", stall_cnt); end
    endtask

    task automatic test_simul_inc_dec();
        issue_write(3'd2);
        dec_valid = 1; ld_mm = 1; dmm = 2; wb_ld_mm = 1; wb_dmm = 2;
        #1;
        n_cmp++; if (mm_issue !== 1'b1) begin n_err++; $display("FAIL simul_issue: got %b want 1", mm_issue); end
        step();
        idle();
        #1;
        n_cmp++; if (pend_mask !== 8'h04) begin n_err++; $display("FAIL simul_pend: got %h want 04", pend_mask); end
        wb_ld_mm = 1; wb_dmm = 2;
        step();
        idle();
        #1;
        n_cmp++; if ({pend_mask, sb_err} !== 9'h000) begin n_err++; $display("FAIL simul_cnt_one: got %h want 000", {pend_mask, sb_err}); end
    endtask

    task automatic test_flush();
        issue_write(3'd0);
        issue_write(3'd4);
        issue_write(3'd7);
        idle();
        #1;
        n_cmp++; if (pend_mask !== 8'h91) begin n_err++; $display("FAIL flush_pre_pend: got %h want 91", pend_mask); end
        dec_valid = 1; mm1_needed = 1; mm1 = 0; ld_mm = 1; dmm = 1; flush = 1; wb_ld_mm = 1; wb_dmm = 4;
        #1;
        n_cmp++; if ({mm_stall, mm_issue} !== 2'b00) begin n_err++; $display("FAIL flush_outputs: got %b want 00", {mm_stall, mm_issue}); end
        step();
        idle();
        #1;
        n_cmp++; if ({pend_mask, sb_err} !== 9'h000) begin n_err++; $display("FAIL flush_cleared: got %h want 000", {pend_mask, sb_err}); end
        flush = 1; wb_ld_mm = 1; wb_dmm = 6;
        step();
        idle();
        #1;
        n_cmp++; if (sb_err !== 1'b0) begin n_err++; $display("FAIL flush_wb_discard: got %b want 0", sb_err); end
    endtask

    task automatic test_spurious_wb();
        idle(); wb_ld_mm = 1; wb_dmm = 6;
        step();
        idle();
        #1;
        n_cmp++; if ({pend_mask, sb_err} !== 9'h001) begin n_err++; $display("FAIL spur_set: got %h want 001", {pend_mask, sb_err}); end
        step();
        step();
        n_cmp++; if (sb_err !== 1'b1) begin n_err++; $display("FAIL spur_sticky: got %b want 1", sb_err); end
    endtask

    task automatic test_stall_cnt();
        issue_write(3'd1);
        idle(); dec_valid = 1; mm2_needed = 1; mm2 = 1;
        for (int k = 0; k < 10; k++) step();
        idle();
        #1;
        n_cmp++; if (stall_cnt !== 16'd12) begin n_err++; $display("FAIL stall_cnt_10: got %0d want 12", stall_cnt); end
        dec_valid = 1; ld_mm = 1; dmm = 2; ds_stall = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if ({mm_stall, mm_issue} !== 2'b00) begin n_err++; $display("FAIL ds_only%0d: got %b want 00", k, {mm_stall, mm_issue}); end
            step();
        end
        idle();
        #1;
        n_cmp++; if (stall_cnt !== 16'd12) begin n_err++; $display("FAIL ds_stall_cnt: got %0d want 12", stall_cnt); end
        n_cmp++; if (pend_mask !== 8'h02) begin n_err++; $display("FAIL ds_pend: got %h want 02", pend_mask); end
    endtask

    task automatic test_async_reset();
        idle(); dec_valid = 1; mm2_needed = 1; mm2 = 1;
        #1;
        n_cmp++; if (mm_stall !== 1'b1) begin n_err++; $display("FAIL rst_pre_stall: got %b want 1", mm_stall); end
        step();
        n_cmp++; if (stall_cnt !== 16'd13) begin n_err++; $display("FAIL rst_pre_cnt: got %0d want 13", stall_cnt); end
        #1;
        rst = 1;
        #1;
        n_cmp++; if ({pend_mask, sb_err, mm_stall} !== 10'h000) begin n_err++; $display("FAIL rst_async_state: got %h want 000", {pend_mask, sb_err, mm_stall}); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_async_cnt: got %0d want 0", stall_cnt); end
        idle();
        step();
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_basic_raw();
        test_counter_full();
        test_simul_inc_dec();
        test_flush();
        test_spurious_wb();
        test_stall_cnt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
